// File: rtl/xge_pkt_rx_bridge.sv
// XGE MAC packet RX interface to valid/ready stream bridge, buffered by a credit-controlled FWFT FIFO.
// Statistics counters are built only when XGE_RX_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for pkt_rx_avail with FIFO credit available
// READ  | issuing pkt_rx_ren until the EOP word comes back
// GAP   | one-cycle pause while the MAC drops pkt_rx_avail
module xge_pkt_rx_bridge #(
    parameter int DATA_W = 64,
    parameter int MOD_W  = $clog2(DATA_W/8),
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clkTxRx,
    input  logic              reset_156m25_n,
    input  logic              pkt_rx_avail,
    output logic              pkt_rx_ren,
    input  logic [DATA_W-1:0] pkt_rx_data,
    input  logic              pkt_rx_val,
    input  logic              pkt_rx_sop,
    input  logic              pkt_rx_eop,
    input  logic              pkt_rx_err,
    input  logic [MOD_W-1:0]  pkt_rx_mod,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_err,
    output logic [MOD_W-1:0]  out_mod,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              framing_err,
    output logic [CNT_W-1:0]  stat_pkt_cnt,
    output logic [CNT_W-1:0]  stat_err_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = DATA_W + MOD_W + 3;

    typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

    state_t           state;
    logic             inflight;
    logic             in_pkt;
    logic [LVL_W-1:0] level;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] head;
    logic [LVL_W:0]   credit_sum;
    logic             credit_ok;
    logic             rx_last;
    logic             wr_req;
    logic             full;
    logic             push;
    logic             pop;

    // Words already requested but not yet written still consume a slot.
    assign credit_sum = {1'b0, level} + {{LVL_W{1'b0}}, inflight} + {{LVL_W{1'b0}}, 1'b1};
    assign credit_ok  = credit_sum <= (LVL_W+1)'(DEPTH);
    assign rx_last    = pkt_rx_val && pkt_rx_eop;
    assign pkt_rx_ren = (state == READ) && credit_ok && !rx_last;

    assign wr_req    = pkt_rx_val && (pkt_rx_sop || in_pkt);
    assign full      = level == LVL_W'(DEPTH);
    assign out_valid = level != '0;
    assign pop       = out_valid && out_ready;
    assign push      = wr_req && (!full || pop);

    always_ff @(posedge clkTxRx or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state    <= IDLE;
            inflight <= 1'b0;
        end else begin
            inflight <= pkt_rx_ren;
            case (state)
                IDLE:    if (pkt_rx_avail && credit_ok) state <= READ;
                READ:    if (rx_last) state <= GAP;
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clkTxRx or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            in_pkt      <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            framing_err <= pkt_rx_val && (pkt_rx_sop ? in_pkt : !in_pkt);
            if (wr_req) in_pkt <= !pkt_rx_eop;
        end
    end

    // Storage is not reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clkTxRx) begin
        if (push)
            mem[wr_ptr] <= {pkt_rx_err, pkt_rx_eop, pkt_rx_sop,
                            (pkt_rx_eop ? pkt_rx_mod : {MOD_W{1'b0}}), pkt_rx_data};
    end

    always_ff @(posedge clkTxRx or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head       = out_valid ? mem[rd_ptr] : '0;
    assign out_data   = head[DATA_W-1:0];
    assign out_mod    = head[DATA_W +: MOD_W];
    assign out_sop    = head[DATA_W+MOD_W];
    assign out_eop    = head[DATA_W+MOD_W+1];
    assign out_err    = head[DATA_W+MOD_W+2];
    assign fifo_level = level;

`ifdef XGE_RX_STATS_EN
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] err_cnt;

    always_ff @(posedge clkTxRx or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else if (pop && out_eop) begin
            if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
            if (out_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
    end

    assign stat_pkt_cnt = pkt_cnt;
    assign stat_err_cnt = err_cnt;
`else
    assign stat_pkt_cnt = '0;
    assign stat_err_cnt = '0;
`endif

endmodule

// File: tb/tb_xge_pkt_rx_bridge.sv
// Randomised scoreboard bench for xge_pkt_rx_bridge: a MAC model feeds packets, a monitor checks the stream.
// A second instance with DATA_W=128 checks the wider MOD field.
module tb_xge_pkt_rx_bridge;

    localparam int DW  = 64;
    localparam int MW  = 3;
    localparam int LW  = 4;
    localparam int CW  = 32;
    localparam int DWW = 128;
    localparam int MWW = 4;

    typedef struct {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic         err;
        logic [3:0]   mod;
    } word_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          pkt_rx_avail, pkt_rx_ren, pkt_rx_val, pkt_rx_sop, pkt_rx_eop, pkt_rx_err;
    logic [DW-1:0] pkt_rx_data;
    logic [MW-1:0] pkt_rx_mod;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready, out_sop, out_eop, out_err, framing_err;
    logic [MW-1:0] out_mod;
    logic [LW-1:0] fifo_level;
    logic [CW-1:0] stat_pkt_cnt, stat_err_cnt;

    logic           w_avail, w_ren, w_val, w_sop, w_eop, w_err;
    logic [DWW-1:0] w_data;
    logic [MWW-1:0] w_mod;
    logic [DWW-1:0] w_out_data;
    logic           w_out_valid, w_out_ready, w_out_sop, w_out_eop, w_out_err, w_framing_err;
    logic [MWW-1:0] w_out_mod;
    logic [LW-1:0]  w_fifo_level;
    logic [CW-1:0]  w_stat_pkt_cnt, w_stat_err_cnt;

    xge_pkt_rx_bridge #(.DATA_W(DW), .DEPTH(8), .CNT_W(CW)) dut (
        .clkTxRx(clk), .reset_156m25_n(rst_n),
        .pkt_rx_avail(pkt_rx_avail), .pkt_rx_ren(pkt_rx_ren), .pkt_rx_data(pkt_rx_data),
        .pkt_rx_val(pkt_rx_val), .pkt_rx_sop(pkt_rx_sop), .pkt_rx_eop(pkt_rx_eop),
        .pkt_rx_err(pkt_rx_err), .pkt_rx_mod(pkt_rx_mod),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err), .out_mod(out_mod),
        .fifo_level(fifo_level), .framing_err(framing_err),
        .stat_pkt_cnt(stat_pkt_cnt), .stat_err_cnt(stat_err_cnt)
    );

    xge_pkt_rx_bridge #(.DATA_W(DWW), .DEPTH(8), .CNT_W(CW)) dut_wide (
        .clkTxRx(clk), .reset_156m25_n(rst_n),
        .pkt_rx_avail(w_avail), .pkt_rx_ren(w_ren), .pkt_rx_data(w_data),
        .pkt_rx_val(w_val), .pkt_rx_sop(w_sop), .pkt_rx_eop(w_eop),
        .pkt_rx_err(w_err), .pkt_rx_mod(w_mod),
        .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_sop(w_out_sop), .out_eop(w_out_eop), .out_err(w_out_err), .out_mod(w_out_mod),
        .fifo_level(w_fifo_level), .framing_err(w_framing_err),
        .stat_pkt_cnt(w_stat_pkt_cnt), .stat_err_cnt(w_stat_err_cnt)
    );

    int    vectors = 0;
    int    miscompares = 0;
    word_t mac_q[$];
    word_t exp_q[$];
    word_t macw_q[$];
    word_t expw_q[$];
    int    mac_pkts = 0;
    int    macw_pkts = 0;
    bit    m_in_pkt = 1'b0;
    int    exp_fr = 0;
    int    obs_fr = 0;
    int    obs_fr_w = 0;
    int    exp_pkt = 0;
    int    exp_err = 0;
    int    exp_pkt_w = 0;
    int    rdy_pct = 100;
    logic  ren_s = 1'b0;
    int    max_lvl = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: words the bridge must stream, derived from the framing rules.
    task automatic present_word(input word_t w);
        word_t e;
        pkt_rx_val  = 1'b1;
        pkt_rx_data = w.data[DW-1:0];
        pkt_rx_sop  = w.sop;
        pkt_rx_eop  = w.eop;
        pkt_rx_err  = w.err;
        pkt_rx_mod  = w.mod[MW-1:0];
        if (!m_in_pkt && !w.sop) begin
            exp_fr++;
        end else begin
            if (w.sop && m_in_pkt) exp_fr++;
            e = w;
            e.data[127:DW] = '0;
            e.mod = w.eop ? {1'b0, w.mod[MW-1:0]} : 4'd0;
            exp_q.push_back(e);
            m_in_pkt = !w.eop;
        end
    endtask

    task automatic idle_inputs();
        pkt_rx_val  = 1'b0;
        pkt_rx_sop  = 1'b0;
        pkt_rx_eop  = 1'b0;
        pkt_rx_err  = 1'b0;
        pkt_rx_mod  = MW'($urandom_range(7));
        pkt_rx_data = {$urandom, $urandom};
    endtask

    task automatic add_pkt(input int len, input bit err, input logic [3:0] mod);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.data = {$urandom, $urandom, $urandom, $urandom};
            w.sop  = (i == 0);
            w.eop  = (i == len - 1);
            w.err  = w.eop ? err : 1'b0;
            w.mod  = w.eop ? mod : 4'($urandom_range(15));
            mac_q.push_back(w);
        end
        mac_pkts++;
    endtask

    // One MAC cycle: ren seen before an edge returns a word just after it.
    task automatic step();
        word_t w;
        @(negedge clk);
        ren_s = pkt_rx_ren;
        @(posedge clk);
        #1;
        if (ren_s && mac_q.size() > 0) begin
            w = mac_q.pop_front();
            if (w.eop) mac_pkts--;
            present_word(w);
        end else begin
            if (ren_s) chk("read_past_eop", ren_s, 0);
            idle_inputs();
        end
        pkt_rx_avail = (mac_pkts > 0);
        out_ready    = ($urandom_range(99) < rdy_pct);
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((mac_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        repeat (3) step();
        chk({name, "_drain_left"}, 128'(mac_q.size() + exp_q.size()), 0);
    endtask

    task automatic check_stats(input string name);
`ifdef XGE_RX_STATS_EN
        chk({name, "_stat_pkt"}, stat_pkt_cnt, 128'(exp_pkt));
        chk({name, "_stat_err"}, stat_err_cnt, 128'(exp_err));
`else
        chk({name, "_stat_pkt"}, stat_pkt_cnt, 0);
        chk({name, "_stat_err"}, stat_err_cnt, 0);
`endif
    endtask

    task automatic run_wide();
        word_t w;
        word_t e;
        logic  rw;
        int    n = 0;
        for (int i = 0; i < 2; i++) begin
            w.data = {$urandom, $urandom, $urandom, $urandom};
            w.sop  = (i == 0);
            w.eop  = (i == 1);
            w.err  = 1'b0;
            w.mod  = (i == 1) ? 4'd9 : 4'd6;
            macw_q.push_back(w);
        end
        macw_pkts   = 1;
        w_avail     = 1'b1;
        w_out_ready = 1'b1;
        while ((macw_q.size() != 0 || expw_q.size() != 0) && n < 40) begin
            @(negedge clk);
            rw = w_ren;
            @(posedge clk);
            #1;
            if (rw && macw_q.size() > 0) begin
                w = macw_q.pop_front();
                if (w.eop) macw_pkts--;
                w_val = 1'b1; w_data = w.data; w_sop = w.sop; w_eop = w.eop;
                w_err = w.err; w_mod = w.mod;
                e = w;
                e.mod = w.eop ? w.mod : 4'd0;
                expw_q.push_back(e);
            end else begin
                if (rw) chk("w_read_past_eop", rw, 0);
                w_val = 1'b0; w_sop = 1'b0; w_eop = 1'b0;
            end
            w_avail = (macw_pkts > 0);
            n++;
        end
        repeat (3) @(posedge clk);
        chk("w_drain_left", 128'(macw_q.size() + expw_q.size()), 0);
    endtask

    logic          hold_v = 1'b0;
    logic [DW+MW+2:0] hold_word;
    logic [DW+MW+2:0] cur_word;
    assign cur_word = {out_err, out_eop, out_sop, out_mod, out_data};

    always @(negedge clk) begin
        word_t e;
        if (!rst_n) begin
            exp_pkt   = 0;
            exp_err   = 0;
            exp_pkt_w = 0;
            hold_v    = 1'b0;
        end else begin
            if (framing_err) obs_fr++;
            if (w_framing_err) obs_fr_w++;
            if (hold_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_stable", cur_word, hold_word);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_sop", out_sop, e.sop);
                    chk("out_eop", out_eop, e.eop);
                    chk("out_err", out_err, e.err);
                    chk("out_mod", out_mod, e.mod);
                    if (e.eop) begin
                        exp_pkt++;
                        if (e.err) exp_err++;
                    end
                end
            end
            hold_v    = out_valid && !out_ready;
            hold_word = cur_word;
            if (w_out_valid && w_out_ready) begin
                if (expw_q.size() == 0) begin
                    chk("w_unexpected_word", w_out_valid, 0);
                end else begin
                    e = expw_q.pop_front();
                    chk("w_out_data", w_out_data, e.data);
                    chk("w_out_sop", w_out_sop, e.sop);
                    chk("w_out_eop", w_out_eop, e.eop);
                    chk("w_out_mod", w_out_mod, e.mod);
                    if (e.eop) exp_pkt_w++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w;
        int    n;
        rst_n = 1'b0;
        pkt_rx_avail = 1'b0;
        out_ready = 1'b1;
        idle_inputs();
        w_avail = 1'b0; w_val = 1'b0; w_sop = 1'b0; w_eop = 1'b0; w_err = 1'b0;
        w_mod = '0; w_data = '0; w_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ren", pkt_rx_ren, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sop", out_sop, 0);
        chk("rst_out_eop", out_eop, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_mod", out_mod, 0);
        chk("rst_framing", framing_err, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_stat_pkt", stat_pkt_cnt, 0);
        chk("rst_stat_err", stat_err_cnt, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // 3-word packet, consumer always ready
        rdy_pct = 100;
        add_pkt(3, 1'b0, 4'd5);
        drain("t1", 60);
        chk("t1_framing_count", 128'(obs_fr), 0);

        // 20-word packet against a stalled consumer
        rdy_pct = 0;
        max_lvl = 0;
        add_pkt(20, 1'b0, 4'd3);
        repeat (40) step();
        chk("t2_level_full", fifo_level, 8);
        chk("t2_max_level", 128'(max_lvl), 8);
        chk("t2_ren_stalled", ren_s, 0);
        rdy_pct = 100;
        drain("t2", 200);

        // back-to-back single-word packets, second flagged bad
        add_pkt(1, 1'b0, 4'd2);
        add_pkt(1, 1'b1, 4'd0);
        drain("t3", 60);
        check_stats("t3");

        // stray val with no sop while idle
        @(posedge clk);
        #1;
        w.data = {$urandom, $urandom, $urandom, $urandom};
        w.sop = 1'b0; w.eop = 1'b0; w.err = 1'b0; w.mod = 4'd1;
        present_word(w);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("t4_framing_pulse", framing_err, 1);
        chk("t4_level", fifo_level, 0);
        @(posedge clk);
        #1;
        chk("t4_framing_clear", framing_err, 0);
        chk("t4_level_after", fifo_level, 0);

        // sop arriving inside a packet starts a new one
        for (int i = 0; i < 4; i++) begin
            w.data = {$urandom, $urandom, $urandom, $urandom};
            w.sop = (i == 0 || i == 2);
            w.eop = (i == 3);
            w.err = 1'b0;
            w.mod = 4'd7;
            mac_q.push_back(w);
        end
        mac_pkts++;
        drain("t4b", 60);
        chk("t4b_framing_count", 128'(obs_fr), 128'(exp_fr));

        // reset with 4 words buffered
        rdy_pct = 0;
        add_pkt(10, 1'b0, 4'd4);
        n = 0;
        while (fifo_level != 4 && n < 40) begin
            step();
            n++;
        end
        chk("t5_level_before", fifo_level, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_out_data", out_data, 0);
        chk("t5_out_sop", out_sop, 0);
        chk("t5_out_mod", out_mod, 0);
        chk("t5_level", fifo_level, 0);
        chk("t5_ren", pkt_rx_ren, 0);
        chk("t5_stat_pkt", stat_pkt_cnt, 0);
        mac_q.delete();
        exp_q.delete();
        mac_pkts = 0;
        m_in_pkt = 1'b0;
        pkt_rx_avail = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        rdy_pct = 100;
        add_pkt(2, 1'b0, 4'd6);
        drain("t5", 60);
        check_stats("t5");

        // randomised traffic with random back-pressure
        rdy_pct = 70;
        for (int p = 0; p < 10; p++)
            add_pkt($urandom_range(1, 12), 1'($urandom_range(1)), 4'($urandom_range(7)));
        drain("t6", 800);
        check_stats("t6");
        chk("t6_framing_count", 128'(obs_fr), 128'(exp_fr));

        // wide instance: 2-word packet with mod=9
        run_wide();
        chk("w_level", w_fifo_level, 0);
        chk("w_framing_count", 128'(obs_fr_w), 0);
`ifdef XGE_RX_STATS_EN
        chk("w_stat_pkt", w_stat_pkt_cnt, 128'(exp_pkt_w));
`else
        chk("w_stat_pkt", w_stat_pkt_cnt, 0);
`endif
        chk("w_stat_err", w_stat_err_cnt, 0);
        chk("w_out_err_idle", w_out_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
